// File: rtl/tdm_demux16_pkg.sv
// rtl/tdm_demux16_pkg.sv - shared TDM framing constants and state encoding
// Frame length and slot width depend on TDM_PARITY_CHECK_EN.
package tdm_demux16_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

`ifdef TDM_PARITY_CHECK_EN
    localparam int FRAME_LEN = NUM_CH + 1;
    localparam int CNT_W     = SEL_W + 1;
`else
    localparam int FRAME_LEN = NUM_CH;
    localparam int CNT_W     = SEL_W;
`endif

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic even_parity(input logic [NUM_CH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tdm_demux16_if.sv
// rtl/tdm_demux16_if.sv - serial input and parallel output bundle of the TDM demux
// parity_err exists only when TDM_PARITY_CHECK_EN is defined.
interface tdm_demux16_if;
    import tdm_demux16_pkg::*;

    logic              din;
    logic              din_valid;
    logic              frame_sync;
    logic [NUM_CH-1:0] dout;
    logic              frame_valid;
    logic [CNT_W-1:0]  slot;
    logic              locked;
    logic              sync_err;
`ifdef TDM_PARITY_CHECK_EN
    logic              parity_err;
`endif

    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, slot, locked, sync_err
`ifdef TDM_PARITY_CHECK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, slot, locked, sync_err
`ifdef TDM_PARITY_CHECK_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - modulo-FRAME_LEN slot counter with clear, load-to-1 and enable
// tc flags the last slot of a frame.
module tdm_slot_counter
    import tdm_demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_W'(1);
        end else if (en) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 16-channel TDM serial-to-parallel demux with framing lock
// Optional parity slot and parity_err output under TDM_PARITY_CHECK_EN.
module tdm_demux16
    import tdm_demux16_pkg::*;
#(
    parameter int MISS_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux16_if.slave   bus
);

    state_t            state, state_nxt;
    logic [2:0]        miss_cnt;
    logic [NUM_CH-1:0] asm_q;
    logic [CNT_W-1:0]  slot;
    logic              tc;

    logic cnt_clr, cnt_load1, cnt_en;
    logic restart, drop, store, complete;
    logic miss_inc, miss_clr, sync_err_nxt;
    logic data_slot;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .en    (cnt_en),
        .count (slot),
        .tc    (tc)
    );

`ifdef TDM_PARITY_CHECK_EN
    assign data_slot = ~slot[SEL_W];
`else
    assign data_slot = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_clr      = 1'b0;
        cnt_load1    = 1'b0;
        cnt_en       = 1'b0;
        restart      = 1'b0;
        drop         = 1'b0;
        store        = 1'b0;
        complete     = 1'b0;
        miss_inc     = 1'b0;
        miss_clr     = 1'b0;
        sync_err_nxt = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_nxt = LOCKED;
                        cnt_load1 = 1'b1;
                        restart   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync && slot != '0) begin
                        // Early sync: realign on this bit as channel 0
                        sync_err_nxt = 1'b1;
                        cnt_load1    = 1'b1;
                        restart      = 1'b1;
                    end else if (slot == '0 && !bus.frame_sync) begin
                        if (int'(miss_cnt) + 1 >= MISS_LIMIT) begin
                            state_nxt = HUNT;
                            cnt_clr   = 1'b1;
                            drop      = 1'b1;
                        end else begin
                            miss_inc = 1'b1;
                            store    = 1'b1;
                            cnt_en   = 1'b1;
                        end
                    end else begin
                        miss_clr = (slot == '0);
                        store    = 1'b1;
                        cnt_en   = 1'b1;
                        complete = tc;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q           <= '0;
            miss_cnt        <= '0;
            bus.dout        <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
            bus.parity_err  <= 1'b0;
`endif
        end else begin
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= sync_err_nxt;
`ifdef TDM_PARITY_CHECK_EN
            bus.parity_err  <= 1'b0;
`endif
            if (restart) begin
                asm_q    <= {{(NUM_CH-1){1'b0}}, bus.din};
                miss_cnt <= '0;
            end
            if (drop) begin
                asm_q    <= '0;
                miss_cnt <= '0;
            end
            if (miss_inc) begin
                miss_cnt <= miss_cnt + 3'd1;
            end
            if (miss_clr) begin
                miss_cnt <= '0;
            end
            if (store && data_slot) begin
                asm_q[slot[SEL_W-1:0]] <= bus.din;
            end
            if (complete) begin
                bus.frame_valid <= 1'b1;
`ifdef TDM_PARITY_CHECK_EN
                bus.dout        <= asm_q;
                bus.parity_err  <= even_parity(asm_q) ^ bus.din;
`else
                bus.dout        <= {bus.din, asm_q[NUM_CH-2:0]};
`endif
            end
        end
    end

    assign bus.slot   = slot;
    assign bus.locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux16.sv
// tb/tb_tdm_demux16.sv - directed self-checking bench for tdm_demux16
module tb_tdm_demux16;
    import tdm_demux16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fv_cnt = 0;
    int   fv_last = 0;
    int   prev_fv;

    always #5 clk = ~clk;

    tdm_demux16_if bus ();

    tdm_demux16 #(.MISS_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic v, input logic fs);
        bus.din        = b;
        bus.din_valid  = v;
        bus.frame_sync = fs;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            fv_last = cyc;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic sync);
        logic b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < NUM_CH) b = w[i[3:0]];
            else            b = ^w;
            send_bit(b, 1'b1, sync && (i == 0));
        end
    endtask

    initial begin
        logic [15:0] w;
        rst            = 1'b0;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_fv", bus.frame_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_slot", bus.slot, 0);
        chk("rst_sync_err", bus.sync_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send_bit(1'b0, 1'b0, 1'b1);
        chk("sync_no_valid_locked", bus.locked, 0);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("hunt_discard_locked", bus.locked, 0);
        chk("hunt_discard_slot", bus.slot, 0);

        // reset then lock: 0x0001
        fv_cnt = 0;
        send_bit(1'b1, 1'b1, 1'b1);
        chk("lock_locked", bus.locked, 1);
        chk("lock_slot", bus.slot, 1);
        for (int i = 1; i < FRAME_LEN; i++) send_bit(i == NUM_CH, 1'b1, 1'b0);
        chk("lock_dout", bus.dout, 32'h0001);
        chk("lock_fv", bus.frame_valid, 1);
        chk("lock_fv_cnt", fv_cnt, 1);
        chk("lock_slot_wrap", bus.slot, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("lock_fv_pulse", bus.frame_valid, 0);
        chk("lock_dout_hold", bus.dout, 32'h0001);

        // walking one, back-to-back frames
        fv_cnt  = 0;
        prev_fv = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w = 16'(1) << k;
            send_frame(w, 1'b1);
            chk("walk_dout", bus.dout, 32'(w));
            chk("walk_fv", bus.frame_valid, 1);
            if (k > 0) chk("walk_spacing", fv_last - prev_fv, FRAME_LEN);
            prev_fv = fv_last;
        end
        chk("walk_fv_cnt", fv_cnt, NUM_CH);

        // gapped valid: 0xA5C3
        fv_cnt = 0;
        w = 16'hA5C3;
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_bit((i < NUM_CH) ? w[i[3:0]] : ^w, 1'b1, i == 0);
            if (i < FRAME_LEN - 1) begin
                send_bit(1'b1, 1'b0, 1'b1);
                chk("gap_slot", bus.slot, (i + 1) % FRAME_LEN);
                chk("gap_locked", bus.locked, 1);
            end
        end
        chk("gap_dout", bus.dout, 32'hA5C3);
        chk("gap_fv_cnt", fv_cnt, 1);

        // early sync at 6th bit
        fv_cnt = 0;
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        chk("early_slot5", bus.slot, 5);
        send_bit(1'b1, 1'b1, 1'b1);
        chk("early_sync_err", bus.sync_err, 1);
        chk("early_slot", bus.slot, 1);
        chk("early_locked", bus.locked, 1);
        chk("early_no_fv", fv_cnt, 0);
        for (int i = 1; i < FRAME_LEN; i++) begin
            send_bit(i < NUM_CH, 1'b1, 1'b0);
            if (i == 1) chk("early_sync_err_pulse", bus.sync_err, 0);
        end
        chk("early_dout", bus.dout, 32'hFFFF);
        chk("early_fv_cnt", fv_cnt, 1);

        // lost lock after 3 missing syncs
        fv_cnt = 0;
        send_frame(16'h1111, 1'b0);
        chk("miss1_dout", bus.dout, 32'h1111);
        chk("miss1_locked", bus.locked, 1);
        send_frame(16'h2222, 1'b0);
        chk("miss2_dout", bus.dout, 32'h2222);
        chk("miss2_locked", bus.locked, 1);
        chk("miss2_fv_cnt", fv_cnt, 2);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("miss3_locked", bus.locked, 0);
        chk("miss3_slot", bus.slot, 0);
        for (int i = 1; i < FRAME_LEN; i++) send_bit(1'b1, 1'b1, 1'b0);
        chk("hunt_slot", bus.slot, 0);
        chk("hunt_fv_cnt", fv_cnt, 2);
        chk("hunt_dout", bus.dout, 32'h2222);
        send_frame(16'h0F0F, 1'b1);
        chk("relock_dout", bus.dout, 32'h0F0F);
        chk("relock_locked", bus.locked, 1);
        chk("relock_fv_cnt", fv_cnt, 3);
`ifdef TDM_PARITY_CHECK_EN
        chk("parity_ok", bus.parity_err, 0);
`endif

        // async reset mid-frame
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1, 1'b0);
        chk("mid_slot", bus.slot, 8);
        #2 rst = 1'b1;
        #1;
        chk("async_dout", bus.dout, 0);
        chk("async_locked", bus.locked, 0);
        chk("async_slot", bus.slot, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(16'h8001, 1'b1);
        chk("post_rst_dout", bus.dout, 32'h8001);

`ifdef TDM_PARITY_CHECK_EN
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < FRAME_LEN; i++) send_bit(1'b0, 1'b1, 1'b0);
        chk("parity_err", bus.parity_err, 1);
        chk("parity_dout", bus.dout, 32'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
